// File: rtl/hureader_pkg.sv
// Shared constants for the HuCard bus sequencer: register map, sequencer
// states, MISC bit positions and the default ID byte.
package hureader_pkg;

  localparam logic [2:0] REG_ADL      = 3'd0;
  localparam logic [2:0] REG_ADM      = 3'd1;
  localparam logic [2:0] REG_ADH      = 3'd2;
  localparam logic [2:0] REG_DATA     = 3'd3;
  localparam logic [2:0] REG_DATA_INC = 3'd4;
  localparam logic [2:0] REG_MISC     = 3'd5;
  localparam logic [2:0] REG_WAIT     = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  localparam int MISC_RST_N    = 0;
  localparam int MISC_SM       = 1;
  localparam int MISC_CSUM_CLR = 6;
  localparam int MISC_ERR_CLR  = 7;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/hucard_bus_sequencer_if.sv
// Host-side register port of the HuCard bus sequencer; the host PIO decode
// drives the master side, the sequencer implements the slave side.
interface hucard_bus_sequencer_if;
  logic [2:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_wr;
  logic       host_rd;
  logic [7:0] host_rdata;
  logic       host_busy;

  modport master (
    output host_addr, host_wdata, host_wr, host_rd,
    input  host_rdata, host_busy
  );

  modport slave (
    input  host_addr, host_wdata, host_wr, host_rd,
    output host_rdata, host_busy
  );
endinterface

// File: rtl/hucard_bus_sequencer_strobe_sequencer.sv
// Card-cycle FSM: SETUP, then STROBE for wait_len+1 clocks, then HOLD.
// Produces the active-low strobes, the data output enable and the read latch.
module strobe_sequencer
  import hureader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       is_write,
  input  logic [3:0] wait_len,
  output logic       done,
  output logic       busy,
  output logic       latch,
  output logic       rd_n,
  output logic       wr_n,
  output logic       oe
);

  seq_state_t state, state_next;
  logic [3:0] count, count_next;
  logic       write_q, write_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      write_q <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      write_q <= write_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    write_next = write_q;
    done       = 1'b0;
    busy       = 1'b1;
    latch      = 1'b0;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    oe         = write_q;
    case (state)
      IDLE: begin
        busy = 1'b0;
        oe   = 1'b0;
        if (start) begin
          state_next = SETUP;
          count_next = wait_len;
          write_next = is_write;
        end
      end
      SETUP: state_next = STROBE;
      STROBE: begin
        rd_n = write_q;
        wr_n = ~write_q;
        // Count reaching zero marks the last strobe clock; reads capture there.
        if (count == 4'd0) begin
          state_next = HOLD;
          latch      = ~write_q;
        end else begin
          count_next = count - 4'd1;
        end
      end
      HOLD: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/hucard_bus_sequencer.sv
// HuCard bus sequencer top: host register file, address/buffer, status
// synchronisers. Optional checksum of read bytes under HUCARD_CHECKSUM_EN.
module hucard_bus_sequencer
  import hureader_pkg::*;
#(
  parameter int         ADDR_W       = 21,
  parameter logic [3:0] WAIT_DEFAULT = 4'd3,
  parameter logic [7:0] ID_VALUE     = ID_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  hucard_bus_sequencer_if.slave host,
  output logic [ADDR_W-1:0]     card_addr,
  output logic [7:0]            card_dout,
  output logic                  card_dout_oe,
  input  logic [7:0]            card_din,
  output logic                  card_rd_n,
  output logic                  card_wr_n,
  output logic                  card_rst_n,
  output logic                  card_sm,
  input  logic                  card_detect_n,
  input  logic                  card_irq_n
);

  logic [ADDR_W-1:0] addr, addr_next;
  logic [7:0]        buffer;
  logic [3:0]        wait_reg;
  logic              err;
  logic              inc_pending;
  logic              detect_n_p0, detect_n_p1, irq_n_p0, irq_n_p1;
  logic              seq_done, seq_busy, seq_latch;
  logic              wr_cmd, rd_cmd, launch_req, start, collide, start_write;
  logic [7:0]        rd_mux;
  logic [7:0]        csum;

  // A simultaneous write and read is treated as the write alone.
  assign wr_cmd      = host.host_wr;
  assign rd_cmd      = host.host_rd & ~host.host_wr;
  assign start_write = wr_cmd && (host.host_addr == REG_DATA || host.host_addr == REG_DATA_INC);
  assign launch_req  = start_write
                     || (wr_cmd && host.host_addr == REG_ADL)
                     || (rd_cmd && host.host_addr == REG_DATA_INC);
  assign start       = launch_req & ~seq_busy;
  assign collide     = launch_req & seq_busy;

  assign host.host_busy = seq_busy;

  strobe_sequencer u_seq (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .is_write (start_write),
    .wait_len (wait_reg),
    .done     (seq_done),
    .busy     (seq_busy),
    .latch    (seq_latch),
    .rd_n     (card_rd_n),
    .wr_n     (card_wr_n),
    .oe       (card_dout_oe)
  );

  // Post-write increment lands in HOLD; host byte writes then overlay it.
  always_comb begin
    addr_next = addr;
    if (seq_done && inc_pending) addr_next = addr + ADDR_W'(1);
    if (wr_cmd) begin
      case (host.host_addr)
        REG_ADL: if (!seq_busy) addr_next[7:0] = host.host_wdata;
        REG_ADM: addr_next[15:8] = host.host_wdata;
        REG_ADH: addr_next[ADDR_W-1:16] = host.host_wdata[ADDR_W-17:0];
        default: ;
      endcase
    end
    if (start && rd_cmd) addr_next = addr + ADDR_W'(1);
  end

  always_comb begin
    rd_mux = 8'h00;
    case (host.host_addr)
      REG_ADL:      rd_mux = addr[7:0];
      REG_ADM:      rd_mux = addr[15:8];
      REG_ADH:      rd_mux = 8'(addr[ADDR_W-1:16]);
      REG_DATA:     rd_mux = buffer;
      REG_DATA_INC: rd_mux = buffer;
      REG_MISC:     rd_mux = {err, seq_busy, 2'b00, detect_n_p1, irq_n_p1, card_sm, card_rst_n};
`ifdef HUCARD_CHECKSUM_EN
      REG_WAIT:     rd_mux = csum;
`else
      REG_WAIT:     rd_mux = {4'b0000, wait_reg};
`endif
      REG_ID:       rd_mux = ID_VALUE;
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr            <= '0;
      card_addr       <= '0;
      card_dout       <= 8'h00;
      buffer          <= 8'h00;
      wait_reg        <= WAIT_DEFAULT;
      err             <= 1'b0;
      inc_pending     <= 1'b0;
      card_rst_n      <= 1'b0;
      card_sm         <= 1'b0;
      host.host_rdata <= 8'h00;
      detect_n_p0     <= 1'b1;
      detect_n_p1     <= 1'b1;
      irq_n_p0        <= 1'b1;
      irq_n_p1        <= 1'b1;
    end else begin
      addr        <= addr_next;
      detect_n_p0 <= card_detect_n;
      detect_n_p1 <= detect_n_p0;
      irq_n_p0    <= card_irq_n;
      irq_n_p1    <= irq_n_p0;
      // The card-side address is frozen at launch so mid-cycle ADM/ADH
      // writes only reach the next cycle.
      if (start) begin
        card_addr   <= addr_next;
        inc_pending <= start_write && (host.host_addr == REG_DATA_INC);
        if (start_write) card_dout <= host.host_wdata;
      end else if (seq_done) begin
        inc_pending <= 1'b0;
      end
      if (seq_latch) buffer <= card_din;
      if (collide) err <= 1'b1;
      else if (wr_cmd && host.host_addr == REG_MISC && host.host_wdata[MISC_ERR_CLR]) err <= 1'b0;
      if (wr_cmd && host.host_addr == REG_MISC) begin
        card_rst_n <= host.host_wdata[MISC_RST_N];
        card_sm    <= host.host_wdata[MISC_SM];
      end
      if (wr_cmd && host.host_addr == REG_WAIT) wait_reg <= host.host_wdata[3:0];
      if (rd_cmd) host.host_rdata <= rd_mux;
    end
  end

`ifdef HUCARD_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (wr_cmd && host.host_addr == REG_MISC && host.host_wdata[MISC_CSUM_CLR]) begin
      csum <= 8'h00;
    end else if (seq_latch) begin
      csum <= csum + card_din;
    end
  end
`else
  assign csum = 8'h00;
`endif

endmodule
